// File: rtl/time_set_controller_pkg.sv
// Shared mode encodings and digit-blank masks for the time-set controller.
package time_set_controller_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HRS = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_BAD     = 2'd3
    } mode_e;

    // Digit order is {hrs2, hrs1, min2, min1}; 1 = blanked.
    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_HRS  = 4'b1100;
    localparam logic [3:0] BLANK_MIN  = 4'b0011;

    // True for the two states in which the user drives the strobes.
    function automatic logic is_set(input mode_e m);
        return (m == MODE_SET_HRS) || (m == MODE_SET_MIN);
    endfunction

    // Blank the field being edited only during the invisible half of the blink.
    function automatic logic [3:0] blank_mask(input mode_e m, input logic phase);
        logic [3:0] mask;
        mask = BLANK_NONE;
        if (phase) begin
            if (m == MODE_SET_HRS)      mask = BLANK_HRS;
            else if (m == MODE_SET_MIN) mask = BLANK_MIN;
        end
        return mask;
    endfunction

endpackage

// File: rtl/time_set_controller_auto_repeat.sv
// Auto-repeat for a held button: first tick after HOLD_CYCLES, then every REPEAT_CYCLES.
module time_set_controller_auto_repeat #(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic CLK100MHZ,
    input  logic Reset_n,
    input  logic btn_up_p,
    input  logic btn_up_lvl,
    output logic up_tick
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          hold_done;

    // Hold counter arms on the press and saturates at HOLD_CYCLES; the repeat
    // counter then cycles 1..REPEAT_CYCLES. Releasing the button clears both.
    always_comb begin
        hold_done = (hold_q == HW'(HOLD_CYCLES));
        up_tick   = btn_up_lvl && hold_done &&
                    ((rep_q == '0) || (rep_q == RW'(REPEAT_CYCLES)));
        hold_d    = hold_q;
        rep_d     = rep_q;
        if (!btn_up_lvl) begin
            hold_d = '0;
            rep_d  = '0;
        end else if (btn_up_p) begin
            hold_d = HW'(1);
            rep_d  = '0;
        end else if (hold_q != '0) begin
            if (!hold_done) hold_d = hold_q + HW'(1);
            if (up_tick)
                rep_d = RW'(1);
            else if ((rep_q != '0) && (rep_q != RW'(REPEAT_CYCLES)))
                rep_d = rep_q + RW'(1);
        end
    end

    // Counter state registers.
    always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Mode/sequencing controller: chooses whether the seconds chain or the user
// drives the minute/hour strobes, with set-mode timeout and digit blinking.
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES   = 50_000_000,
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned REPEAT_CYCLES  = 10_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       Reset_n,
    input  logic       btnMode_p,
    input  logic       btnUp_p,
    input  logic       btnUp_lvl,
    input  logic       sec_wrap,
    input  logic       min_wrap,
    output logic       inc_min,
    output logic       inc_hrs,
    output logic       clr_sec,
    output logic       run_en,
    output logic [3:0] digit_blank,
    output logic [1:0] mode
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    mode_e         mode_q, mode_d;
    logic [TW-1:0] to_q, to_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          inc_min_q, inc_min_d;
    logic          inc_hrs_q, inc_hrs_d;
    logic          clr_sec_q, clr_sec_d;
    logic          run_en_q, run_en_d;
    logic [3:0]    blank_q, blank_d;

    logic          up_tick;
    logic          up_evt;
    logic          activity;
    logic          to_hit;

    time_set_controller_auto_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_auto_repeat (
        .CLK100MHZ  (CLK100MHZ),
        .Reset_n    (Reset_n),
        .btn_up_p   (btnUp_p),
        .btn_up_lvl (btnUp_lvl),
        .up_tick    (up_tick)
    );

    // Next-state, strobe, timeout and blink decisions for the coming cycle.
    always_comb begin
        up_evt    = btnUp_p | up_tick;
        activity  = btnMode_p | btnUp_p | btnUp_lvl;
        to_hit    = is_set(mode_q) && !activity &&
                    (to_q == TW'(TIMEOUT_CYCLES - 1));

        mode_d    = mode_q;
        inc_min_d = 1'b0;
        inc_hrs_d = 1'b0;
        clr_sec_d = 1'b0;

        case (mode_q)
            MODE_RUN: begin
                inc_min_d = sec_wrap;
                inc_hrs_d = min_wrap;
                if (btnMode_p) mode_d = MODE_SET_HRS;
            end
            MODE_SET_HRS: begin
                // A mode press swallows a coincident up event.
                if (btnMode_p) begin
                    mode_d = MODE_SET_MIN;
                end else if (to_hit) begin
                    mode_d    = MODE_RUN;
                    clr_sec_d = 1'b1;
                end else begin
                    inc_hrs_d = up_evt;
                end
            end
            MODE_SET_MIN: begin
                if (btnMode_p || to_hit) begin
                    mode_d    = MODE_RUN;
                    clr_sec_d = 1'b1;
                end else begin
                    inc_min_d = up_evt;
                end
            end
            default: mode_d = MODE_RUN;
        endcase

        // Inactivity counter only lives inside an unbroken, idle set state.
        if (is_set(mode_d) && (mode_d == mode_q) && !activity)
            to_d = (to_q == TW'(TIMEOUT_CYCLES)) ? to_q : to_q + TW'(1);
        else
            to_d = '0;

        // Blink restarts visible on any state entry and on each adjustment.
        if (!is_set(mode_d) || (mode_d != mode_q) || up_evt) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (blink_q == BW'(BLINK_CYCLES - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + BW'(1);
            phase_d = phase_q;
        end

        run_en_d = !is_set(mode_d);
        blank_d  = blank_mask(mode_d, phase_d);
    end

    // State, counters and all outputs are registered together.
    always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_q    <= MODE_RUN;
            to_q      <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            inc_min_q <= 1'b0;
            inc_hrs_q <= 1'b0;
            clr_sec_q <= 1'b0;
            run_en_q  <= 1'b1;
            blank_q   <= BLANK_NONE;
        end else begin
            mode_q    <= mode_d;
            to_q      <= to_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            inc_min_q <= inc_min_d;
            inc_hrs_q <= inc_hrs_d;
            clr_sec_q <= clr_sec_d;
            run_en_q  <= run_en_d;
            blank_q   <= blank_d;
        end
    end

    assign inc_min     = inc_min_q;
    assign inc_hrs     = inc_hrs_q;
    assign clr_sec     = clr_sec_q;
    assign run_en      = run_en_q;
    assign digit_blank = blank_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with a strobe scoreboard.
module tb_time_set_controller;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic       btnMode_p, btnUp_p, btnUp_lvl, sec_wrap, min_wrap;
    logic       inc_min, inc_hrs, clr_sec, run_en;
    logic [3:0] digit_blank;
    logic [1:0] mode;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    // Expected strobe: posedge index after which it is visible, and {inc_min,inc_hrs,clr_sec}.
    typedef struct {
        int         at;
        logic [2:0] v;
    } exp_t;
    exp_t exp_q[$];

    time_set_controller #(
        .BLINK_CYCLES   (4),
        .HOLD_CYCLES    (8),
        .REPEAT_CYCLES  (3),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .CLK100MHZ   (clk),
        .Reset_n     (Reset_n),
        .btnMode_p   (btnMode_p),
        .btnUp_p     (btnUp_p),
        .btnUp_lvl   (btnUp_lvl),
        .sec_wrap    (sec_wrap),
        .min_wrap    (min_wrap),
        .inc_min     (inc_min),
        .inc_hrs     (inc_hrs),
        .clr_sec     (clr_sec),
        .run_en      (run_en),
        .digit_blank (digit_blank),
        .mode        (mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, req);
        end
    endtask

    task automatic expect_strobe(input int at, input logic [2:0] v);
        exp_t e;
        e.at = at;
        e.v  = v;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every visible strobe must match the oldest expectation; overdue ones are misses.
    always @(negedge clk) begin
        logic [2:0] strb;
        exp_t       e;
        strb = {inc_min, inc_hrs, clr_sec};
        if (strb != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {29'd0, strb}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.at);
                chk("strobe_value", {29'd0, strb}, {29'd0, e.v});
            end
        end else begin
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_strobe", {29'd0, strb}, {29'd0, e.v});
            end
        end
    end

    initial begin
        int p, e, u;
        Reset_n   = 1'b0;
        btnMode_p = 1'b0;
        btnUp_p   = 1'b0;
        btnUp_lvl = 1'b0;
        sec_wrap  = 1'b0;
        min_wrap  = 1'b0;

        // Reset state
        step(3);
        chk("rst_mode", {30'd0, mode}, 32'd0);
        chk("rst_run_en", {31'd0, run_en}, 32'd1);
        chk("rst_blank", {28'd0, digit_blank}, 32'd0);
        chk("rst_strobes", {29'd0, inc_min, inc_hrs, clr_sec}, 32'd0);
        Reset_n = 1'b1;

        // RUN: seconds/minute wraps drive strobes; up button ignored
        while (cyc < 9) step(1);
        sec_wrap = 1'b1; expect_strobe(cyc + 1, 3'b100); step(1); sec_wrap = 1'b0;
        chk("run_mode", {30'd0, mode}, 32'd0);
        chk("run_run_en", {31'd0, run_en}, 32'd1);
        step(2);
        min_wrap = 1'b1; expect_strobe(cyc + 1, 3'b010); step(1); min_wrap = 1'b0;
        step(1);
        sec_wrap = 1'b1; min_wrap = 1'b1; expect_strobe(cyc + 1, 3'b110); step(1);
        sec_wrap = 1'b0; min_wrap = 1'b0;
        btnUp_p = 1'b1; btnUp_lvl = 1'b1; step(1); btnUp_p = 1'b0; btnUp_lvl = 1'b0;
        step(2);

        // SET_HRS: up presses give inc_hrs, wraps ignored
        btnMode_p = 1'b1; step(1); btnMode_p = 1'b0;
        chk("sethrs_mode", {30'd0, mode}, 32'd1);
        chk("sethrs_run_en", {31'd0, run_en}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            btnUp_p = 1'b1; btnUp_lvl = 1'b1; expect_strobe(cyc + 1, 3'b010); step(1);
            btnUp_p = 1'b0; btnUp_lvl = 1'b0; step(1);
        end
        sec_wrap = 1'b1; min_wrap = 1'b1; step(1); sec_wrap = 1'b0; min_wrap = 1'b0;
        step(2);
        chk("sethrs_still", {30'd0, mode}, 32'd1);

        // SET_MIN: held button auto-repeats
        btnMode_p = 1'b1; step(1); btnMode_p = 1'b0;
        chk("setmin_mode", {30'd0, mode}, 32'd2);
        chk("setmin_run_en", {31'd0, run_en}, 32'd0);
        p = cyc + 1;
        btnUp_p = 1'b1; btnUp_lvl = 1'b1;
        expect_strobe(p, 3'b100);
        expect_strobe(p + 8, 3'b100);
        expect_strobe(p + 11, 3'b100);
        expect_strobe(p + 14, 3'b100);
        expect_strobe(p + 17, 3'b100);
        step(1); btnUp_p = 1'b0;
        step(19); btnUp_lvl = 1'b0;
        step(10);

        // SET_MIN -> RUN on mode press clears seconds
        btnMode_p = 1'b1; expect_strobe(cyc + 1, 3'b001); step(1); btnMode_p = 1'b0;
        chk("exit_mode", {30'd0, mode}, 32'd0);
        chk("exit_run_en", {31'd0, run_en}, 32'd1);
        step(2);

        // SET_HRS idle: blink pattern, then timeout back to RUN
        e = cyc + 1;
        btnMode_p = 1'b1; expect_strobe(e + 50, 3'b001); step(1); btnMode_p = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("blink_idle", {28'd0, digit_blank}, ((k / 4) % 2) ? 32'hC : 32'h0);
            step(1);
        end
        while (cyc < e + 49) step(1);
        chk("timeout_not_early", {30'd0, mode}, 32'd1);
        step(1);
        chk("timeout_mode", {30'd0, mode}, 32'd0);
        chk("timeout_run_en", {31'd0, run_en}, 32'd1);
        chk("timeout_blank", {28'd0, digit_blank}, 32'd0);
        step(2);

        // Up press forces digits visible and restarts blink
        e = cyc + 1;
        btnMode_p = 1'b1; step(1); btnMode_p = 1'b0;
        step(5);
        chk("blink_before_up", {28'd0, digit_blank}, 32'hC);
        u = cyc + 1;
        btnUp_p = 1'b1; btnUp_lvl = 1'b1; expect_strobe(u, 3'b010); step(1);
        btnUp_p = 1'b0; btnUp_lvl = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("blink_after_up", {28'd0, digit_blank}, 32'h0);
            step(1);
        end
        chk("blink_resume", {28'd0, digit_blank}, 32'hC);

        // Mode press wins over coincident up press
        btnMode_p = 1'b1; btnUp_p = 1'b1; btnUp_lvl = 1'b1; step(1);
        btnMode_p = 1'b0; btnUp_p = 1'b0; btnUp_lvl = 1'b0;
        chk("mode_wins", {30'd0, mode}, 32'd2);
        step(2);

        // Async reset during a SET_MIN strobe
        btnUp_p = 1'b1; btnUp_lvl = 1'b1; expect_strobe(cyc + 1, 3'b100); step(1);
        btnUp_p = 1'b0; btnUp_lvl = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        chk("async_rst_mode", {30'd0, mode}, 32'd0);
        chk("async_rst_run_en", {31'd0, run_en}, 32'd1);
        chk("async_rst_blank", {28'd0, digit_blank}, 32'd0);
        chk("async_rst_strobes", {29'd0, inc_min, inc_hrs, clr_sec}, 32'd0);
        step(3);
        Reset_n = 1'b1;
        step(1);
        chk("post_rst_mode", {30'd0, mode}, 32'd0);
        sec_wrap = 1'b1; expect_strobe(cyc + 1, 3'b100); step(1); sec_wrap = 1'b0;
        step(3);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
